// File: rtl/icache_pkg.sv
// Shared definitions for the direct-mapped instruction cache controller.
package icache_pkg;

  typedef enum logic {
    IC_IDLE = 1'b0,
    IC_MISS = 1'b1
  } ic_state_t;

  // PCs are byte addresses of 32-bit words; the low two bits never select anything.
  localparam int WORD_OFF = 2;

endpackage

// File: rtl/icache_array.sv
// Valid/tag/data storage: one combinational read port, one synchronous write port.
// Only the valid bits are reset; tag and data contents are don't-care until written.
module icache_array
  import icache_pkg::*;
#(
  parameter int IDX_W = 6,
  parameter int TAG_W = 32 - IDX_W - WORD_OFF
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [IDX_W-1:0] rd_idx,
  output logic             rd_valid,
  output logic [TAG_W-1:0] rd_tag,
  output logic [31:0]      rd_data,
  input  logic             wr_en,
  input  logic [IDX_W-1:0] wr_idx,
  input  logic [TAG_W-1:0] wr_tag,
  input  logic [31:0]      wr_data
);

  localparam int DEPTH = 1 << IDX_W;

  logic [DEPTH-1:0] valid;
  logic [TAG_W-1:0] tags [DEPTH];
  logic [31:0]      data [DEPTH];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid <= '0;
    end else if (wr_en) begin
      valid[wr_idx] <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (wr_en) begin
      tags[wr_idx] <= wr_tag;
      data[wr_idx] <= wr_data;
    end
  end

  assign rd_valid = valid[rd_idx];
  assign rd_tag   = tags[rd_idx];
  assign rd_data  = data[rd_idx];

endmodule

// File: rtl/icache_ctrl.sv
// Direct-mapped instruction cache controller: hit service, miss fill, rollback, rdy freeze.
// Optional feature macro: ICACHE_PERF_EN enables the hit/miss performance counters.
module icache_ctrl
  import icache_pkg::*;
#(
  parameter int IDX_W = 6
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        rdy,
  input  logic        rollback,
  input  logic        fetch_req,
  input  logic [31:0] fetch_pc,
  output logic        fetch_ok,
  output logic [31:0] fetch_ins,
  output logic        mem_miss,
  output logic [31:0] mem_pc,
  input  logic        mem_finish,
  input  logic [31:0] mem_ins,
  output logic [31:0] hit_cnt,
  output logic [31:0] miss_cnt
);

  localparam int TAG_W = 32 - IDX_W - WORD_OFF;

  ic_state_t        state;
  logic             rd_valid;
  logic [TAG_W-1:0] rd_tag;
  logic [31:0]      rd_data;
  logic             hit;
  logic             accept;
  logic             fill;
  logic             unused_pc_bits;

  assign unused_pc_bits = ^fetch_pc[WORD_OFF-1:0];

  icache_array #(
    .IDX_W (IDX_W),
    .TAG_W (TAG_W)
  ) u_array (
    .clk      (clk),
    .rst_n    (rst_n),
    .rd_idx   (fetch_pc[IDX_W+WORD_OFF-1:WORD_OFF]),
    .rd_valid (rd_valid),
    .rd_tag   (rd_tag),
    .rd_data  (rd_data),
    .wr_en    (fill),
    .wr_idx   (mem_pc[IDX_W+WORD_OFF-1:WORD_OFF]),
    .wr_tag   (mem_pc[31:IDX_W+WORD_OFF]),
    .wr_data  (mem_ins)
  );

  assign hit    = rd_valid && (rd_tag == fetch_pc[31:IDX_W+WORD_OFF]);
  assign accept = rdy && !rollback && (state == IC_IDLE) && fetch_req && !fetch_ok;
  // A fill completing under rollback still lands: the data is correct for mem_pc.
  assign fill   = rdy && (state == IC_MISS) && mem_finish;

  assign mem_miss = (state == IC_MISS) && !mem_finish;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IC_IDLE;
      fetch_ok  <= 1'b0;
      fetch_ins <= '0;
      mem_pc    <= '0;
    end else if (rdy) begin
      fetch_ok <= 1'b0;
      if (rollback) begin
        state <= IC_IDLE;
      end else if (state == IC_IDLE) begin
        if (fetch_req && !fetch_ok) begin
          if (hit) begin
            fetch_ok  <= 1'b1;
            fetch_ins <= rd_data;
          end else begin
            mem_pc <= {fetch_pc[31:WORD_OFF], {WORD_OFF{1'b0}}};
            state  <= IC_MISS;
          end
        end
      end else if (mem_finish) begin
        fetch_ok  <= 1'b1;
        fetch_ins <= mem_ins;
        state     <= IC_IDLE;
      end
    end
  end

`ifdef ICACHE_PERF_EN
  logic [31:0] hit_q;
  logic [31:0] miss_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hit_q  <= '0;
      miss_q <= '0;
    end else begin
      if (accept && hit) hit_q <= hit_q + 32'd1;
      if (accept && !hit) miss_q <= miss_q + 32'd1;
    end
  end

  assign hit_cnt  = hit_q;
  assign miss_cnt = miss_q;
`else
  assign hit_cnt  = '0;
  assign miss_cnt = '0;
`endif

endmodule

// File: tb/tb_icache_ctrl.sv
// Self-checking bench for icache_ctrl against a line-map reference model.
module tb_icache_ctrl;

  localparam int IDX_W = 6;
  localparam int LINES = 1 << IDX_W;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        rdy = 1'b1;
  logic        rollback = 1'b0;
  logic        fetch_req = 1'b0;
  logic [31:0] fetch_pc = '0;
  logic        mem_finish = 1'b0;
  logic [31:0] mem_ins = '0;
  logic        fetch_ok;
  logic [31:0] fetch_ins;
  logic        mem_miss;
  logic [31:0] mem_pc;
  logic [31:0] hit_cnt;
  logic [31:0] miss_cnt;

  int vectors = 0;
  int errors = 0;

  // Reference model: line number -> word address held there, plus its data.
  logic [29:0] m_addr [int];
  logic [31:0] m_data [int];
  int exp_hits = 0;
  int exp_misses = 0;

  icache_ctrl #(.IDX_W(IDX_W)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .rdy        (rdy),
    .rollback   (rollback),
    .fetch_req  (fetch_req),
    .fetch_pc   (fetch_pc),
    .fetch_ok   (fetch_ok),
    .fetch_ins  (fetch_ins),
    .mem_miss   (mem_miss),
    .mem_pc     (mem_pc),
    .mem_finish (mem_finish),
    .mem_ins    (mem_ins),
    .hit_cnt    (hit_cnt),
    .miss_cnt   (miss_cnt)
  );

  always #5 clk = ~clk;

  function automatic int line_of(input logic [31:0] pc);
    return int'((pc >> 2) % LINES);
  endfunction

  function automatic bit m_hit(input logic [31:0] pc);
    int l;
    l = line_of(pc);
    if (!m_addr.exists(l)) return 1'b0;
    return m_addr[l] == pc[31:2];
  endfunction

  function automatic logic [31:0] exp_cnt(input int n);
`ifdef ICACHE_PERF_EN
    return 32'(n);
`else
    return 32'(n - n);
`endif
  endfunction

  task automatic m_fill(input logic [31:0] pc, input logic [31:0] d);
    m_addr[line_of(pc)] = pc[31:2];
    m_data[line_of(pc)] = d;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // One complete fetch transaction, expectations taken from the model.
  task automatic do_fetch(input logic [31:0] pc, input int delay, input logic [31:0] ins);
    logic [31:0] exp_d;
    fetch_pc  = pc;
    fetch_req = 1'b1;
    if (m_hit(pc)) begin
      exp_d = m_data[line_of(pc)];
      exp_hits++;
      step();
      vectors++;
      if (fetch_ok !== 1'b1 || fetch_ins !== exp_d || mem_miss !== 1'b0) begin
        errors++;
        $display("[TB] FAIL hit_resp pc=%h got ok=%b ins=%h miss=%b want ok=1 ins=%h miss=0",
                 pc, fetch_ok, fetch_ins, mem_miss, exp_d);
      end
    end else begin
      exp_misses++;
      step();
      for (int d = 0; d < delay; d++) begin
        vectors++;
        if (mem_miss !== 1'b1 || mem_pc !== {pc[31:2], 2'b00} || fetch_ok !== 1'b0) begin
          errors++;
          $display("[TB] FAIL miss_req pc=%h got miss=%b mem_pc=%h ok=%b want miss=1 mem_pc=%h ok=0",
                   pc, mem_miss, mem_pc, fetch_ok, {pc[31:2], 2'b00});
        end
        step();
      end
      mem_finish = 1'b1;
      mem_ins    = ins;
      #1;
      vectors++;
      if (mem_miss !== 1'b0 || mem_pc !== {pc[31:2], 2'b00}) begin
        errors++;
        $display("[TB] FAIL finish_drop got miss=%b mem_pc=%h want miss=0 mem_pc=%h",
                 mem_miss, mem_pc, {pc[31:2], 2'b00});
      end
      step();
      mem_finish = 1'b0;
      vectors++;
      if (fetch_ok !== 1'b1 || fetch_ins !== ins) begin
        errors++;
        $display("[TB] FAIL fill_resp pc=%h got ok=%b ins=%h want ok=1 ins=%h", pc, fetch_ok, fetch_ins, ins);
      end
      m_fill(pc, ins);
    end
    fetch_req = 1'b0;
    step();
    vectors++;
    if (fetch_ok !== 1'b0 || hit_cnt !== exp_cnt(exp_hits) || miss_cnt !== exp_cnt(exp_misses)) begin
      errors++;
      $display("[TB] FAIL post_fetch got ok=%b hits=%0d misses=%0d want ok=0 hits=%0d misses=%0d",
               fetch_ok, hit_cnt, miss_cnt, exp_cnt(exp_hits), exp_cnt(exp_misses));
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    #1;
    vectors++;
    if (fetch_ok !== 1'b0 || fetch_ins !== '0 || mem_miss !== 1'b0 || mem_pc !== '0 ||
        hit_cnt !== '0 || miss_cnt !== '0) begin
      errors++;
      $display("[TB] FAIL reset_vals got ok=%b ins=%h miss=%b mem_pc=%h hits=%0d misses=%0d want all 0",
               fetch_ok, fetch_ins, mem_miss, mem_pc, hit_cnt, miss_cnt);
    end
    step();
    step();
    rst_n = 1'b1;
    step();
  endtask

  task automatic test_cold_miss();
    do_fetch(32'h0000_0104, 5, 32'h00A0_0093);
  endtask

  task automatic test_hit_after_fill();
    do_fetch(32'h0000_0106, 0, 32'h0);
  endtask

  task automatic test_conflict();
    do_fetch(32'h0000_0204, 3, 32'h1111_2222);
    do_fetch(32'h0000_0104, 2, 32'h3333_4444);
  endtask

  task automatic test_rollback();
    fetch_pc  = 32'h0000_0308;
    fetch_req = 1'b1;
    exp_misses++;
    step();
    step();
    vectors++;
    if (mem_miss !== 1'b1) begin
      errors++;
      $display("[TB] FAIL rb_pre got miss=%b want 1", mem_miss);
    end
    rollback  = 1'b1;
    fetch_req = 1'b0;
    step();
    rollback = 1'b0;
    vectors++;
    if (mem_miss !== 1'b0 || fetch_ok !== 1'b0) begin
      errors++;
      $display("[TB] FAIL rb_abort got miss=%b ok=%b want miss=0 ok=0", mem_miss, fetch_ok);
    end
    step();
    do_fetch(32'h0000_0308, 1, 32'h5555_6666);

    // Rollback coinciding with mem_finish still fills the line.
    fetch_pc  = 32'h0000_040C;
    fetch_req = 1'b1;
    exp_misses++;
    step();
    mem_finish = 1'b1;
    mem_ins    = 32'hCAFE_F00D;
    rollback   = 1'b1;
    fetch_req  = 1'b0;
    step();
    mem_finish = 1'b0;
    rollback   = 1'b0;
    vectors++;
    if (fetch_ok !== 1'b0 || mem_miss !== 1'b0) begin
      errors++;
      $display("[TB] FAIL rb_finish got ok=%b miss=%b want ok=0 miss=0", fetch_ok, mem_miss);
    end
    m_fill(32'h0000_040C, 32'hCAFE_F00D);
    step();
    do_fetch(32'h0000_040C, 0, 32'h0);
  endtask

  task automatic test_rdy_stall();
    fetch_pc  = 32'h0000_050C;
    fetch_req = 1'b1;
    exp_misses++;
    step();
    step();
    mem_finish = 1'b1;
    mem_ins    = 32'hDEAD_BEEF;
    rdy        = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step();
      mem_finish = 1'b0;
      #1;
      vectors++;
      if (fetch_ok !== 1'b0 || mem_miss !== 1'b1 || mem_pc !== 32'h0000_050C) begin
        errors++;
        $display("[TB] FAIL stall_hold got ok=%b miss=%b mem_pc=%h want ok=0 miss=1 mem_pc=0000050c",
                 fetch_ok, mem_miss, mem_pc);
      end
    end
    rdy        = 1'b1;
    mem_finish = 1'b1;
    step();
    mem_finish = 1'b0;
    vectors++;
    if (fetch_ok !== 1'b1 || fetch_ins !== 32'hDEAD_BEEF) begin
      errors++;
      $display("[TB] FAIL stall_fill got ok=%b ins=%h want ok=1 ins=deadbeef", fetch_ok, fetch_ins);
    end
    m_fill(32'h0000_050C, 32'hDEAD_BEEF);
    rdy = 1'b0;
    step();
    vectors++;
    if (fetch_ok !== 1'b1) begin
      errors++;
      $display("[TB] FAIL stall_ok_hold got ok=%b want 1", fetch_ok);
    end
    rdy       = 1'b1;
    fetch_req = 1'b0;
    step();
    vectors++;
    if (fetch_ok !== 1'b0 || miss_cnt !== exp_cnt(exp_misses)) begin
      errors++;
      $display("[TB] FAIL stall_end got ok=%b misses=%0d want ok=0 misses=%0d",
               fetch_ok, miss_cnt, exp_cnt(exp_misses));
    end
    do_fetch(32'h0000_050C, 0, 32'h0);
  endtask

  task automatic test_back_to_back();
    logic [31:0] pcs [4];
    int k;
    int last;
    for (int i = 0; i < 4; i++) begin
      pcs[i] = 32'h0000_1040 + 32'(4 * i);
      do_fetch(pcs[i], 1, $urandom);
    end
    k = 0;
    last = 0;
    fetch_pc  = pcs[0];
    fetch_req = 1'b1;
    for (int cyc = 0; cyc < 20 && k < 4; cyc++) begin
      step();
      if (fetch_ok === 1'b1) begin
        exp_hits++;
        vectors++;
        if (fetch_ins !== m_data[line_of(pcs[k])] || (k > 0 && cyc - last != 2)) begin
          errors++;
          $display("[TB] FAIL b2b_pulse k=%0d got ins=%h gap=%0d want ins=%h gap=2",
                   k, fetch_ins, cyc - last, m_data[line_of(pcs[k])]);
        end
        last = cyc;
        k++;
        if (k < 4) fetch_pc = pcs[k];
      end
    end
    fetch_req = 1'b0;
    vectors++;
    if (k != 4) begin
      errors++;
      $display("[TB] FAIL b2b_count got %0d pulses want 4", k);
    end
    for (int i = 0; i < 3; i++) begin
      step();
      vectors++;
      if (fetch_ok !== 1'b0 || mem_miss !== 1'b0) begin
        errors++;
        $display("[TB] FAIL b2b_extra got ok=%b miss=%b want 0 0", fetch_ok, mem_miss);
      end
    end
  endtask

  task automatic test_random();
    logic [31:0] pc;
    for (int i = 0; i < 40; i++) begin
      pc = {22'(32'h50 + $urandom % 3), 6'(40 + $urandom % 4), 2'($urandom % 4)};
      do_fetch(pc, int'($urandom % 4), $urandom);
    end
  endtask

  task automatic test_reset_mid_miss();
    fetch_pc  = 32'h0000_060C;
    fetch_req = 1'b1;
    step();
    rst_n = 1'b0;
    #1;
    vectors++;
    if (mem_miss !== 1'b0 || fetch_ok !== 1'b0 || mem_pc !== '0 || fetch_ins !== '0 ||
        hit_cnt !== '0 || miss_cnt !== '0) begin
      errors++;
      $display("[TB] FAIL reset_async got miss=%b ok=%b mem_pc=%h ins=%h hits=%0d misses=%0d want all 0",
               mem_miss, fetch_ok, mem_pc, fetch_ins, hit_cnt, miss_cnt);
    end
    m_addr.delete();
    m_data.delete();
    exp_hits   = 0;
    exp_misses = 0;
    fetch_req  = 1'b0;
    step();
    rst_n = 1'b1;
    step();
    do_fetch(32'h0000_0104, 1, 32'h7777_8888);
    do_fetch(32'h0000_0104, 0, 32'h0);
  endtask

  initial begin
    test_reset();
    test_cold_miss();
    test_hit_after_fill();
    test_conflict();
    test_rollback();
    test_rdy_stall();
    test_back_to_back();
    test_random();
    test_reset_mid_miss();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule

// File: doc/icache_ctrl.md
# icache_ctrl

Direct-mapped instruction cache controller between the instruction fetcher and the memory controller's fetch port. Serves hits from a local tag/data array. On a miss it drives a level miss request carrying the PC to the memory controller, waits for the 32-bit instruction, fills the line and forwards the word. It aborts cleanly on rollback and freezes while `rdy` is low.

## Interface
- `IDX_W`, default 6: index width, giving 2^IDX_W one-word lines; legal range 1..12. Tag width is 30-IDX_W.
- `clk` in 1: clock, rising edge.
- `rst_n` in 1: reset, asynchronous, active-low.
- `rdy` in 1: global ready; low freezes all state and holds all outputs.
- `rollback` in 1: pipeline flush.
- `fetch_req` in 1: fetcher requests the instruction at `fetch_pc` (level).
- `fetch_pc` in 32: byte PC; bits [1:0] are ignored.
- `fetch_ok` out 1: one-cycle response pulse.
- `fetch_ins` out 32: instruction, valid while `fetch_ok`=1.
- `mem_miss` out 1: miss request to the memory controller (level).
- `mem_pc` out 32: word-aligned miss address.
- `mem_finish` in 1: memory controller delivered `mem_ins`.
- `mem_ins` in 32: fetched instruction.
- `hit_cnt` out 32: hit counter (see Configuration).
- `miss_cnt` out 32: miss counter (see Configuration).

## Operation
- Address split:
  - index = `fetch_pc[IDX_W+1:2]`
  - tag = `fetch_pc[31:IDX_W+2]`
  - each line holds a valid bit, a tag and a 32-bit word.
- States: IDLE, MISS.
- IDLE, when `fetch_req`=1 and `fetch_ok`=0 in this cycle (the request is accepted):
  - On a hit (valid and tag match): `fetch_ok`<=1 and `fetch_ins`<=line data; state stays IDLE.
  - On a miss: `mem_pc`<={`fetch_pc[31:2]`,2'b00}; state goes to MISS.
- IDLE while `fetch_ok`=1: `fetch_req` is ignored. The fetcher updates `fetch_pc` on that edge, so double service is impossible. Hit throughput is one per 2 cycles.
- `mem_miss` is combinational: (state==MISS) && !`mem_finish`. It therefore drops in the `mem_finish` cycle, and the memory controller never starts a redundant fetch.
- MISS, when `mem_finish`=1:
  - Line[`mem_pc` index] <= {valid=1, tag of `mem_pc`, `mem_ins`}.
  - `fetch_ok`<=1 and `fetch_ins`<=`mem_ins`.
  - State goes to IDLE.
- `fetch_pc` is held stable by the fetcher during MISS. `mem_pc` is the authoritative address for the fill.
- `rollback`=1, with priority over everything except reset:
  - Next cycle: state is IDLE and `fetch_ok`=0.
  - If `mem_finish`=1 in the same cycle, the line is still filled, because the data is correct for `mem_pc`; no `fetch_ok` is produced.
  - Cache contents are otherwise preserved.
- `rdy`=0: no state, array or counter update. `fetch_ok` holds its value; the fetcher must qualify `fetch_ok` with `rdy`.
- Reset values:
  - state IDLE, all valid bits 0
  - `fetch_ok` 0, `fetch_ins` 0, `mem_pc` 0, `mem_miss` 0
  - `hit_cnt` 0, `miss_cnt` 0
- Tag data arrays need no reset; only the valid bits are reset.

## Timing
- Hit latency: request accepted at edge N, `fetch_ok` high during cycle N+1 for exactly one cycle.
- Miss latency: accepted at edge N, `mem_miss` high from cycle N+1 until the `mem_finish` cycle M; `fetch_ok` high in cycle M+1.
- Fill and same-index lookup: the array write at edge M is visible to a lookup accepted at edge M+2 or later. No bypass is needed, because the lookup at M+1 is blocked by `fetch_ok`.
- Reset asserted mid-miss: all outputs take reset values immediately, asynchronously.

## Configuration
- `ICACHE_PERF_EN` defined:
  - `hit_cnt` increments on each accepted hit; `miss_cnt` increments on each IDLE->MISS transition.
  - Both are 32-bit, wrap modulo 2^32, are cleared only by reset, and are unaffected by `rollback`.
- Undefined: both ports are constant 0 and no counter registers are synthesised.

## Structure
- Shared package: state encoding (`IC_IDLE`, `IC_MISS`) and the word-offset constant 2.
- Sub-module `icache_array`: valid/tag/data storage with one combinational read port (index in; valid, tag, data out), one synchronous write port, and valid-bit clear on `rst_n`.
- The controller FSM, response registers and counters live in `icache_ctrl`.

## Test plan
- Cold miss:
  - Stimulus: reset, `fetch_req`=1, `fetch_pc`=0x00000104; after 5 cycles drive `mem_finish`=1 with `mem_ins`=0x00A00093.
  - Required: `mem_miss` high for 5 cycles with `mem_pc`=0x104; `fetch_ok` pulse next cycle with 0x00A00093; `miss_cnt`=1.
- Hit after fill:
  - Stimulus: re-request 0x106.
  - Required: the low bits are ignored; `fetch_ok` one cycle later with 0x00A00093; `mem_miss` stays 0; `hit_cnt`=1.
- Conflict eviction (`IDX_W`=6):
  - Stimulus: fill 0x104, then request 0x204.
  - Required: miss with `mem_pc`=0x204; the following re-request of 0x104 misses again.
- Rollback mid-miss:
  - Stimulus: assert `rollback` 2 cycles into MISS.
  - Required: `mem_miss` 0 the next cycle, no `fetch_ok`, line not valid.
  - Variant: rollback in the same cycle as `mem_finish` fills the line; a later request hits.
- rdy stall:
  - Stimulus: drop `rdy` for 3 cycles on the `mem_finish` edge.
  - Required: no fill and state held; the fill and `fetch_ok` occur after `rdy` returns, with `mem_finish` re-presented.
- Back-to-back hits:
  - Stimulus: `fetch_req` held high over 4 hitting PCs, `fetch_pc` advancing on each `fetch_ok`.
  - Required: exactly 4 `fetch_ok` pulses, spaced 2 cycles apart.
